// File: rtl/ysyx_22050499_pkg.sv
// Shared definitions for the ysyx_22050499 fetch front end.
//   fetch_state_e    : state of the single-outstanding-request fetch FSM
//   DEFAULT_RESET_PC : address of the first fetch after reset
package ysyx_22050499_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,  // no request outstanding
    FETCH_REQ   = 2'd1,  // request presented, waiting for req_ready
    FETCH_WAIT  = 2'd2,  // request accepted, response pending
    FETCH_DRAIN = 2'd3   // request accepted, response pending and stale
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

endpackage

// File: rtl/ysyx_22050499_sync_fifo.sv
// Synchronous FIFO with flush, used as the fetch instruction queue.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   i_flush        : drop all entries (wins over push and pop in the same cycle)
//   i_push         : write i_push_data at the tail
//   i_push_data    : entry to write
//   i_pop          : remove the head entry (ignored when empty)
//   o_head         : head entry, read from the storage array
//   o_valid        : queue holds at least one entry
//   o_count        : number of entries held, 0..DEPTH
module ysyx_22050499_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_full;

  assign o_valid   = (r_count != '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & o_valid & ~i_flush;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // The producer only issues against free credit, so a push never meets a full queue.
  always_ff @(posedge clock) begin
    if (!reset && w_do_push) assert (!w_full);
  end

endmodule

// File: rtl/ysyx_22050499_ifu_prefetch.sv
// Prefetching instruction-fetch front end.
// Fetches sequential PCs ahead into a QDEPTH-entry queue, one request in flight
// at a time. A redirect flushes the queue, reloads the fetch PC and marks any
// in-flight request stale so its response is discarded.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1.
// req_valid/req_addr never change or withdraw until req_ready; resp_valid has
// no ready and is always consumed; out_valid/out_pc/out_inst hold until out_ready.
//
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr    : memory read request channel
//   resp_valid/resp_data            : memory read response (never back-pressured)
//   redirect_valid/redirect_pc      : control-flow redirect to a new fetch target
//   out_valid/out_ready/out_pc/out_inst : instruction stream toward decode
//   fetch_pc                        : next address to be requested (trace)
//   o_dbg_state, o_dbg_count        : FSM state and queue occupancy (debug)
module ysyx_22050499_ifu_prefetch
  import ysyx_22050499_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [ADDR_W-1:0]        req_addr,
  input  logic                     resp_valid,
  input  logic [INST_W-1:0]        resp_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic [ADDR_W-1:0]        fetch_pc,
  output fetch_state_e             o_dbg_state,
  output logic [$clog2(QDEPTH):0]  o_dbg_count
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int QW = ADDR_W + INST_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] w_req_addr_nxt;
  logic              r_stale;
  logic              w_stale_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_credit;
  logic [CW-1:0]     w_count;
  logic [QW-1:0]     w_head;

  // Issue only from IDLE (nothing in flight), so free space now covers the response.
  assign w_credit = (w_count < CW'(QDEPTH));
  // The queue ignores the pop when a redirect flushes it in the same cycle.
  assign w_pop    = out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_stale_nxt    = r_stale;
    w_push         = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        if (!redirect_valid && w_credit) begin
          w_state_nxt    = FETCH_REQ;
          w_req_addr_nxt = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
        end
      end
      FETCH_REQ: begin
        // The request is never withdrawn; a redirect only taints it.
        if (req_ready) begin
          w_state_nxt = (r_stale || redirect_valid) ? FETCH_DRAIN : FETCH_WAIT;
          w_stale_nxt = 1'b0;
        end else if (redirect_valid) begin
          w_stale_nxt = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (resp_valid) begin
          w_state_nxt = FETCH_IDLE;
          w_push      = ~redirect_valid;
        end else if (redirect_valid) begin
          w_state_nxt = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (resp_valid) w_state_nxt = FETCH_IDLE;
      end
      default: w_state_nxt = FETCH_IDLE;
    endcase
    if (redirect_valid) w_fetch_pc_nxt = redirect_pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= FETCH_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_stale    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_stale    <= w_stale_nxt;
    end
  end

  ysyx_22050499_sync_fifo #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clock       (clock),
    .reset       (reset),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data ({r_req_addr, resp_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (out_valid),
    .o_count     (w_count)
  );

  assign req_valid   = (r_state == FETCH_REQ);
  assign req_addr    = r_req_addr;
  assign fetch_pc    = r_fetch_pc;
  assign out_pc      = w_head[QW-1:INST_W];
  assign out_inst    = w_head[INST_W-1:0];
  assign o_dbg_state = r_state;
  assign o_dbg_count = w_count;

endmodule

// File: tb/tb_ysyx_22050499_ifu_prefetch.sv
// Testbench for ysyx_22050499_ifu_prefetch: a memory responder with a
// programmable response delay, a scoreboard of expected queue entries,
// directed sequences for the multi-cycle corner cases and a redirect table.
module tb_ysyx_22050499_ifu_prefetch;
  import ysyx_22050499_pkg::*;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int QDEPTH = 4;
  localparam int W      = ADDR_W + INST_W;
  localparam logic [31:0] RST_PC = 32'h3000_0000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clock = ~clock;

  logic              req_valid;
  logic              req_ready = 1'b1;
  logic [31:0]       req_addr;
  logic              resp_valid = 1'b0;
  logic [31:0]       resp_data = '0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic [31:0]       fetch_pc;
  fetch_state_e      dbg_state;
  logic [2:0]        dbg_count;

  ysyx_22050499_ifu_prefetch #(
    .ADDR_W (ADDR_W), .INST_W (INST_W), .QDEPTH (QDEPTH), .RESET_PC (RST_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .fetch_pc       (fetch_pc),
    .o_dbg_state    (dbg_state),
    .o_dbg_count    (dbg_count)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bound(input string name, input bit expired);
    n_checks++;
    if (expired) begin
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // ---------------- scoreboard / memory model ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_next_addr = RST_PC;
  logic [31:0]  req_cur_addr  = '0;
  logic [31:0]  pend_addr     = '0;
  bit           req_prev_open = 0;
  bit           req_stale     = 0;
  bit           pend_busy     = 0;
  bit           pend_stale    = 0;
  int           pend_cnt      = 0;
  int           resp_delay    = 1;
  int           n_req         = 0;
  logic         nxt_resp_valid = 1'b0;
  logic [31:0]  nxt_resp_data  = '0;

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        exp_next_addr = RST_PC;
        req_prev_open = 0;
        req_stale     = 0;
        if (resp_valid) pend_busy = 0;
        if (pend_busy) pend_stale = 1;
      end else begin
        check("queue_count", 64'(dbg_count), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (out_valid && out_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_empty: got pop of pc 0x%0h, expected no entry (t=%0t)", out_pc, $time);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", 64'(out_pc), 64'(e[W-1:INST_W]));
            check("out_inst", 64'(out_inst), 64'(e[INST_W-1:0]));
          end
        end
        if (req_valid) begin
          if (!req_prev_open) begin
            check("req_addr_new", 64'(req_addr), 64'(exp_next_addr));
            req_cur_addr  = exp_next_addr;
            exp_next_addr = exp_next_addr + 32'd4;
            n_req++;
          end else begin
            check("req_addr_hold", 64'(req_addr), 64'(req_cur_addr));
          end
        end
        if (resp_valid && pend_busy) begin
          if (!pend_stale && !redirect_valid) exp_q.push_back({pend_addr, mem_word(pend_addr)});
          pend_busy = 0;
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_next_addr = redirect_pc;
          if (pend_busy) pend_stale = 1;
        end
        if (req_valid && req_ready) begin
          pend_busy  = 1;
          pend_cnt   = resp_delay;
          pend_stale = req_stale | redirect_valid;
          pend_addr  = req_cur_addr;
          req_stale  = 0;
        end else if (req_valid && redirect_valid) begin
          req_stale = 1;
        end
        req_prev_open = req_valid && !req_ready;
      end
      nxt_resp_valid = 1'b0;
      nxt_resp_data  = '0;
      if (pend_busy) begin
        if (pend_cnt <= 1) begin
          nxt_resp_valid = 1'b1;
          nxt_resp_data  = mem_word(pend_addr);
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  initial begin : mem_drv
    forever begin
      @(posedge clock);
      #1;
      resp_valid = nxt_resp_valid;
      resp_data  = nxt_resp_data;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_state(input fetch_state_e st, input int budget, input string name);
    int k = 0;
    tick(1);
    while (dbg_state != st && k < budget) begin
      tick(1);
      k++;
    end
    check_bound(name, dbg_state != st);
  endtask

  task automatic wait_new_req(input int budget, input string name);
    int n0 = n_req;
    int k  = 0;
    do begin
      @(negedge clock);
      #1;
      k++;
    end while (n_req == n0 && k < budget);
    check_bound(name, n_req == n0);
  endtask

  task automatic wait_out_valid(input int budget, input string name);
    int k = 0;
    do begin
      @(negedge clock);
      #1;
      k++;
    end while (!out_valid && k < budget);
    check_bound(name, !out_valid);
  endtask

  // Called just after a rising edge; the redirect is seen for one cycle.
  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_first;
    logic [31:0] exp_next;
  } redir_vec_t;

  redir_vec_t vecs[4];

  initial begin : test
    int n0;
    int k;
    vecs[0] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[1] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vecs[2] = '{32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h8000_0000};
    vecs[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC};

    // Reset values and first-request timing.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_state", 64'(dbg_state), 64'(FETCH_IDLE));
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_addr", 64'(req_addr), 64'd0);
    check("rst_fetch_pc", 64'(fetch_pc), 64'(RST_PC));
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(dbg_count), 64'd0);
    tick(1);
    reset = 1'b0;
    @(negedge clock);
    check("cycle1_req_valid", 64'(req_valid), 64'd0);
    @(negedge clock);
    #1;
    check("cycle2_req_valid", 64'(req_valid), 64'd1);
    check("cycle2_req_addr", 64'(req_addr), 64'(RST_PC));
    @(negedge clock);
    check("cycle3_out_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    #1;
    check("cycle4_out_valid", 64'(out_valid), 64'd1);
    check("cycle4_out_pc", 64'(out_pc), 64'(RST_PC));
    check("cycle4_out_inst", 64'(out_inst), 64'(mem_word(RST_PC)));

    // Zero-wait memory: one request every three cycles.
    n0 = n_req;
    repeat (30) begin
      @(negedge clock);
      #1;
    end
    check("throughput_30cyc", 64'(n_req - n0), 64'd10);

    // Back-pressure: exactly QDEPTH requests from an empty queue.
    tick(1);
    out_ready = 1'b0;
    wait_state(FETCH_IDLE, 30, "bp_wait_idle");
    pulse_redirect(32'h4000_0000);
    n0 = n_req;
    tick(40);
    check("bp_req_issued", 64'(n_req - n0), 64'd4);
    check("bp_count_full", 64'(dbg_count), 64'd4);
    check("bp_req_valid", 64'(req_valid), 64'd0);
    check("bp_head_pc", 64'(out_pc), 64'h4000_0000);
    check("bp_head_inst", 64'(out_inst), 64'(mem_word(32'h4000_0000)));
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(20);
    check("bp_one_more_req", 64'(n_req - n0), 64'd5);
    check("bp_count_refill", 64'(dbg_count), 64'd4);

    // Redirect while WAIT; stale response arrives two cycles later.
    out_ready  = 1'b1;
    resp_delay = 3;
    wait_state(FETCH_WAIT, 40, "rw_wait_state");
    pulse_redirect(32'h8000_0100);
    check("rw_drain_state", 64'(dbg_state), 64'(FETCH_DRAIN));
    wait_new_req(30, "rw_new_req");
    check("rw_req_addr", 64'(req_addr), 64'h8000_0100);
    wait_out_valid(30, "rw_out_valid");
    check("rw_out_pc", 64'(out_pc), 64'h8000_0100);

    // Redirect while REQ with the memory stalling for three cycles.
    tick(1);
    resp_delay = 1;
    req_ready  = 1'b0;
    wait_state(FETCH_REQ, 40, "rr_req_state");
    pulse_redirect(32'h8000_0200);
    tick(2);
    check("rr_still_req", 64'(dbg_state), 64'(FETCH_REQ));
    req_ready = 1'b1;
    tick(1);
    check("rr_drain_state", 64'(dbg_state), 64'(FETCH_DRAIN));
    wait_new_req(30, "rr_new_req");
    check("rr_req_addr", 64'(req_addr), 64'h8000_0200);
    wait_out_valid(30, "rr_out_valid");
    check("rr_out_pc", 64'(out_pc), 64'h8000_0200);

    // Redirect with a full queue and a pop attempt in the same cycle.
    tick(1);
    out_ready = 1'b0;
    k = 0;
    while (dbg_count != 3'd4 && k < 40) begin
      tick(1);
      k++;
    end
    check_bound("rf_fill", dbg_count != 3'd4);
    out_ready = 1'b1;
    pulse_redirect(32'h9000_0000);
    check("rf_out_valid", 64'(out_valid), 64'd0);
    check("rf_count", 64'(dbg_count), 64'd0);
    check("rf_fetch_pc", 64'(fetch_pc), 64'h9000_0000);

    // Redirect table, including address wrap-around.
    for (int i = 0; i < 4; i++) begin
      wait_state(FETCH_IDLE, 30, "tbl_wait_idle");
      pulse_redirect(vecs[i].pc);
      wait_new_req(30, "tbl_first_req");
      check("tbl_first_addr", 64'(req_addr), 64'(vecs[i].exp_first));
      check("tbl_fetch_pc", 64'(fetch_pc), 64'(vecs[i].exp_next));
      wait_new_req(30, "tbl_second_req");
      check("tbl_second_addr", 64'(req_addr), 64'(vecs[i].exp_next));
    end

    // Reset mid-WAIT: the late response must be ignored.
    tick(1);
    resp_delay = 3;
    wait_state(FETCH_WAIT, 40, "rst_wait_state");
    req_ready = 1'b0;
    reset     = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rstw_state", 64'(dbg_state), 64'(FETCH_IDLE));
    check("rstw_fetch_pc", 64'(fetch_pc), 64'(RST_PC));
    check("rstw_count", 64'(dbg_count), 64'd0);
    tick(4);
    check("rstw_req_state", 64'(dbg_state), 64'(FETCH_REQ));
    check("rstw_late_count", 64'(dbg_count), 64'd0);
    check("rstw_late_out_valid", 64'(out_valid), 64'd0);
    check("rstw_req_addr", 64'(req_addr), 64'(RST_PC));
    resp_delay = 1;
    req_ready  = 1'b1;
    wait_out_valid(30, "rstw_out_valid");
    check("rstw_out_pc", 64'(out_pc), 64'(RST_PC));
    check("rstw_out_inst", 64'(out_inst), 64'(mem_word(RST_PC)));

    tick(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
